// File: rtl/data_memory_if.sv
// Load/store port of the word-organised data memory: the execute stage
// drives the address, data and enables, and the memory returns read data.
interface data_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_enable;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output address,
        output write_data,
        output write_enable,
        output read_enable,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  write_enable,
        input  read_enable,
        output read_data
    );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write and synchronous clear-all reset,
// combinational gated read. Out-of-range accesses read as zero and never write.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic               clk,
    input  logic               rst,
    data_memory_if.slave       mem_bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    // The full address is compared so high indices never alias onto low words.
    assign in_range = (mem_bus.address < ADDR_WIDTH'(DEPTH));
    assign idx      = mem_bus.address[IDX_W-1:0];

    always_comb begin
        mem_d = mem_q;
        if (mem_bus.write_enable && in_range) begin
            mem_d[idx] = mem_bus.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        mem_bus.read_data = '0;
        if (mem_bus.read_enable && in_range) begin
            mem_bus.read_data = mem_q[idx];
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed walk through the access rules, then random
// traffic scored against an array model updated on every rising edge.
module tb_data_memory;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [DW-1:0] ref_mem [DEPTH];

    data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_bus ();

    data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_bus (mem_bus)
    );

    always #5 clk = ~clk;

    // Reference: reset wipes everything, otherwise an in-range write lands.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (mem_bus.write_enable && (mem_bus.address < DEPTH)) begin
            ref_mem[mem_bus.address] = mem_bus.write_data;
        end
    end

    function automatic logic [DW-1:0] model_read(logic [AW-1:0] a, logic re);
        if (re && (a < DEPTH)) return ref_mem[a];
        return '0;
    endfunction

    task automatic check_eq(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: read_data=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_in(logic r, logic we, logic re, logic [AW-1:0] a, logic [DW-1:0] wd);
        rst                  = r;
        mem_bus.write_enable = we;
        mem_bus.read_enable  = re;
        mem_bus.address      = a;
        mem_bus.write_data   = wd;
    endtask

    // Apply inputs mid-cycle, then check the combinational read before any edge.
    task automatic drive(string tag, logic r, logic we, logic re, logic [AW-1:0] a,
                         logic [DW-1:0] wd, logic [DW-1:0] exp);
        @(negedge clk);
        set_in(r, we, re, a, wd);
        #1;
        check_eq(tag, mem_bus.read_data, exp);
        check_eq({tag, "_model"}, mem_bus.read_data, model_read(a, re));
    endtask

    task automatic edge_then_check(string tag, logic [DW-1:0] exp);
        @(posedge clk);
        #1;
        check_eq(tag, mem_bus.read_data, exp);
    endtask

    initial begin
        set_in(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;

        drive("rst_rd0",   1'b0, 1'b0, 1'b1, 0,   '0, 32'h0);
        drive("rst_rd10",  1'b0, 1'b0, 1'b1, 10,  '0, 32'h0);
        drive("rst_rd255", 1'b0, 1'b0, 1'b1, 255, '0, 32'h0);

        drive("wr10_pre",  1'b0, 1'b1, 1'b0, 10, 32'hABCDEFFF, 32'h0);
        edge_then_check("wr10_gated", 32'h0);
        drive("rd10",      1'b0, 1'b0, 1'b1, 10, '0, 32'hABCDEFFF);
        drive("rd20",      1'b0, 1'b0, 1'b1, 20, '0, 32'h0);

        drive("gate_off",  1'b0, 1'b0, 1'b0, 10, '0, 32'h0);
        mem_bus.read_enable = 1'b1;
        #1;
        check_eq("gate_on", mem_bus.read_data, 32'hABCDEFFF);

        drive("rw_pre",    1'b0, 1'b1, 1'b1, 10, 32'h12345678, 32'hABCDEFFF);
        edge_then_check("rw_post", 32'h12345678);
        drive("rd11",      1'b0, 1'b0, 1'b1, 11, '0, 32'h0);

        drive("oor_wr",    1'b0, 1'b1, 1'b1, 256, 32'hDEADBEEF, 32'h0);
        edge_then_check("oor_post", 32'h0);
        drive("oor_rd256", 1'b0, 1'b0, 1'b1, 256, '0, 32'h0);
        drive("oor_rd0",   1'b0, 1'b0, 1'b1, 0,   '0, 32'h0);
        drive("oor_rd255", 1'b0, 1'b0, 1'b1, 255, '0, 32'h0);
        drive("wr255",     1'b0, 1'b1, 1'b1, 255, 32'h55AA55AA, 32'h0);
        edge_then_check("wr255_post", 32'h55AA55AA);
        drive("rd255",     1'b0, 1'b0, 1'b1, 255, '0, 32'h55AA55AA);
        drive("rd10_keep", 1'b0, 1'b0, 1'b1, 10,  '0, 32'h12345678);

        drive("rstpri",    1'b1, 1'b1, 1'b1, 5, 32'hFFFFFFFF, 32'h0);
        edge_then_check("rstpri_post", 32'h0);
        drive("rstpri_rd5",  1'b0, 1'b0, 1'b1, 5,   '0, 32'h0);
        drive("rstpri_rd10", 1'b0, 1'b0, 1'b1, 10,  '0, 32'h0);
        drive("rstpri_rd255",1'b0, 1'b0, 1'b1, 255, '0, 32'h0);

        // Random traffic biased toward a small window so words get reused.
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] a;
            logic          r, we, re;
            case ($urandom_range(0, 9))
                0:       a = $urandom();
                1, 2:    a = $urandom_range(DEPTH - 4, DEPTH + 4);
                default: a = $urandom_range(0, 15);
            endcase
            r  = ($urandom_range(0, 99) == 0);
            we = $urandom_range(0, 1);
            re = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            set_in(r, we, re, a, $urandom());
            #1;
            check_eq("rnd_pre", mem_bus.read_data, model_read(a, re));
            @(posedge clk);
            #1;
            check_eq("rnd_post", mem_bus.read_data, model_read(a, re));
        end

        // Sweep every word so any stray write elsewhere is caught.
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 1'b1, a, '0);
            #1;
            check_eq("sweep", mem_bus.read_data, ref_mem[a]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data memory for the single-cycle RISC-V datapath; serves load/store accesses from the execute stage.
- Writes are synchronous on the rising clock edge. Reads are combinational and gated by read_enable.
- Addresses are word indices, not byte addresses.
- Synchronous reset clears every stored word to zero.

Parameters:
- DATA_WIDTH, 32, width of each stored word and of the data ports.
- ADDR_WIDTH, 32, width of the address port.
- DEPTH, 256, number of words stored; must be a power of two ≥ 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- address  input  ADDR_WIDTH  word index of the access.
- write_data  input  DATA_WIDTH  data stored on a write.
- write_enable  input  1  when high, store write_data at address on rising clk edge.
- read_enable  input  1  when high, drive stored word at address onto read_data.
- read_data  output  DATA_WIDTH  combinational read result.

Behaviour:
- Storage: DEPTH words of DATA_WIDTH bits, index 0..DEPTH-1.
- In range: address < DEPTH. Out of range: address ≥ DEPTH. No modulo wrap.
- Reset:
  - On a rising edge with rst=1, all DEPTH words become 0.
  - write_enable is ignored in that cycle; reset has priority over writes.
  - read_data follows the normal combinational rule, so after reset every in-range read returns 0.
- Write:
  - On a rising edge with rst=0, write_enable=1 and address in range, mem[address] <= write_data.
  - Latency 1 edge: new value is visible on read_data immediately after that edge.
  - Out-of-range writes are silently dropped; no other word changes.
- Read:
  - read_data = mem[address] when read_enable=1 and address is in range.
  - read_data = 0 when read_enable=0 or address is out of range.
  - Purely combinational: no clock latency; changes whenever address, read_enable or contents change.
- Simultaneous read and write, same address:
  - Before the edge, read_data shows the old word.
  - After the edge, it shows write_data.
  - No internal bypass.
- read_enable and write_enable may both be high; they are independent.
- X/undriven inputs need no defined behaviour. After the first reset, no word holds X.
- No handshake, no stall, no error output.

Test Plan:
- Reset then read: assert rst for one edge; read_enable=1 at addresses 0, 10, DEPTH-1 -> read_data = 0x00000000 each.
- Write then read: write_enable=1, address=10, write_data=0xABCDEFFF, one edge; then write_enable=0, read_enable=1, address=10 -> read_data = 0xABCDEFFF. Change address to 20 -> read_data = 0x00000000.
- Read gating: after the write above, address=10, read_enable=0 -> read_data = 0; raise read_enable -> 0xABCDEFFF with no clock edge.
- Overwrite and same-address read/write:
  - Hold read_enable=1, address=10; set write_data=0x12345678, write_enable=1.
  - Before the edge read_data = 0xABCDEFFF; after the edge read_data = 0x12345678.
  - Word at address 11 remains 0.
- Out of range: write 0xDEADBEEF at address=DEPTH (256) -> read at 256 returns 0, and words 0 and 255 are unchanged. Write 0x55AA55AA at 255 -> read at 255 returns 0x55AA55AA.
- Reset priority: write_enable=1, rst=1, address=5, write_data=0xFFFFFFFF for one edge -> reading address 5 returns 0, and the previously written address 10 also returns 0.
